// File: rtl/param_logic_accum.sv
// param_logic_accum: registered bitwise gate (AND/OR/XOR/XNOR) with a per-beat mode and a
// frame-checksum mode that XOR-folds beat results. Define PARAM_LOGIC_ACCUM_PARITY_EN to add out_parity.
module param_logic_accum #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic [1:0]       op,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] bitwise_op(input logic [1:0] sel,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        case (sel)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            2'b11:   res = ~(a ^ b);
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // The beat counter sticks at its all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] res;
        if (c == {CNT_W{1'b1}}) begin
            res = c;
        end else begin
            res = c + CNT_W'(1'b1);
        end
        return res;
    endfunction

`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
    function automatic logic parity_fn(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] acc_r, acc_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]       op_q_r, op_q_nxt_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
    logic             out_parity_r;
`endif

    logic             accept_s;
    logic             release_s;
    logic [1:0]       op_sel_s;
    logic [WIDTH-1:0] beat_res_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             load_s;
    logic [WIDTH-1:0] load_data_s;
    logic [CNT_W-1:0] load_count_s;

    assign in_ready   = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign release_s  = out_valid_r && out_ready;
    // Inside an open frame the latched op wins so a frame is folded with a single operation.
    assign op_sel_s   = (state_r == S_ACC) ? op_q_r : op;
    assign beat_res_s = bitwise_op(op_sel_s, in_a, in_b);
    assign cnt_inc_s  = sat_inc(cnt_r);

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_count  = out_count_r;
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
    assign out_parity = out_parity_r;
`endif

    // Next-state, accumulator update and output-load decision.
    always_comb begin
        state_nxt_s  = state_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        op_q_nxt_s   = op_q_r;
        load_s       = 1'b0;
        load_data_s  = beat_res_s;
        load_count_s = CNT_W'(1'b1);
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (mode && !in_last) begin
                        acc_nxt_s   = beat_res_s;
                        cnt_nxt_s   = CNT_W'(1'b1);
                        op_q_nxt_s  = op;
                        state_nxt_s = S_ACC;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ACC: begin
                if (accept_s) begin
                    if (in_last) begin
                        load_s       = 1'b1;
                        load_data_s  = acc_r ^ beat_res_s;
                        load_count_s = cnt_inc_s;
                        acc_nxt_s    = {WIDTH{1'b0}};
                        cnt_nxt_s    = {CNT_W{1'b0}};
                        state_nxt_s  = S_IDLE;
                    end else begin
                        acc_nxt_s = acc_r ^ beat_res_s;
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = S_ACC;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                acc_nxt_s   = {WIDTH{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            op_q_r  <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_q_r  <= op_q_nxt_s;
        end
    end

    // Single output register: a load overrides a same-cycle release, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_count_r  <= {CNT_W{1'b0}};
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
            out_parity_r <= 1'b0;
`endif
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= load_data_s;
            out_count_r  <= load_count_s;
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
            out_parity_r <= parity_fn(load_data_s);
`endif
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_param_logic_accum.sv
// Self-checking bench for param_logic_accum: directed steps plus random traffic against a
// frame-level reference model; a CNT_W=2 twin instance shares the stimulus to cover saturation.
module tb_param_logic_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic [1:0] op;
    logic       mode;
    logic       out_ready;

    logic       in_ready_a, out_valid_a;
    logic [7:0] out_data_a;
    logic [7:0] out_count_a;
    logic       in_ready_b, out_valid_b;
    logic [7:0] out_data_b;
    logic [1:0] out_count_b;
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
    logic       par_a, par_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected pending results and the currently open frame.
    logic [7:0] q_data[$];
    int         q_n[$];
    bit         f_open;
    logic [1:0] f_op;
    logic [7:0] f_acc;
    int         f_n;

    always #5 clk = ~clk;

    param_logic_accum #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .op(op), .mode(mode),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a)
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
        , .out_parity(par_a)
`endif
    );

    param_logic_accum #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .op(op), .mode(mode),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b)
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
        , .out_parity(par_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gate(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        if (o == 2'd0) return a & b;
        else if (o == 2'd1) return a | b;
        else if (o == 2'd2) return a ^ b;
        else return ~(a ^ b);
    endfunction

    function automatic int sat_to(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                         input logic m, input logic l);
        in_valid = 1'b1; in_a = a; in_b = b; op = o; mode = m; in_last = l;
    endtask

    // One clock: check ready, update the model for what the edge will do, then check outputs.
    task automatic tick();
        logic       exp_ready;
        logic [7:0] r;
        #1;
        exp_ready = (q_data.size() == 0) || out_ready;
        chk("in_ready_a", in_ready_a, exp_ready);
        chk("in_ready_b", in_ready_b, exp_ready);
        if (q_data.size() != 0 && out_ready) begin
            void'(q_data.pop_front());
            void'(q_n.pop_front());
        end
        if (in_valid && exp_ready) begin
            if (!f_open) begin
                r = gate(op, in_a, in_b);
                if (mode && !in_last) begin
                    f_open = 1'b1; f_op = op; f_acc = r; f_n = 1;
                end else begin
                    q_data.push_back(r); q_n.push_back(1);
                end
            end else begin
                r = gate(f_op, in_a, in_b);
                f_acc = f_acc ^ r;
                f_n++;
                if (in_last) begin
                    q_data.push_back(f_acc); q_n.push_back(f_n);
                    f_open = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_a", out_valid_a, q_data.size() != 0);
        chk("out_valid_b", out_valid_b, q_data.size() != 0);
        if (q_data.size() != 0) begin
            chk("out_data_a", out_data_a, q_data[0]);
            chk("out_data_b", out_data_b, q_data[0]);
            chk("out_count_a", out_count_a, sat_to(q_n[0], 255));
            chk("out_count_b", out_count_b, sat_to(q_n[0], 3));
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
            chk("out_parity_a", par_a, ^q_data[0]);
            chk("out_parity_b", par_b, ^q_data[0]);
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        q_data.delete(); q_n.delete();
        f_open = 1'b0; f_n = 0; f_acc = 8'h00; f_op = 2'b00;
        #1;
        chk("rst_valid_a", out_valid_a, 1'b0);
        chk("rst_valid_b", out_valid_b, 1'b0);
        chk("rst_data_a", out_data_a, 8'h00);
        chk("rst_count_a", out_count_a, 8'h00);
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
        chk("rst_parity_a", par_a, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pb_exp [4];
        pb_exp[0] = 8'h05; pb_exp[1] = 8'hAF; pb_exp[2] = 8'hAA; pb_exp[3] = 8'h55;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_last = 1'b0;
        op = 2'b00; mode = 1'b0; out_ready = 1'b1;
        do_reset();

        // Per-beat mode, all four operations.
        for (int i = 0; i < 4; i++) begin
            drive(8'hA5, 8'h0F, 2'(i), 1'b0, 1'b0);
            tick();
            chk("pb_data", out_data_a, pb_exp[i]);
            chk("pb_count", out_count_a, 8'd1);
        end
        in_valid = 1'b0;
        tick();

        // Accumulate XOR frame of three beats.
        drive(8'h01, 8'h00, 2'b10, 1'b1, 1'b0); tick();
        chk("acc_no_out1", out_valid_a, 1'b0);
        drive(8'h02, 8'h00, 2'b10, 1'b1, 1'b0); tick();
        chk("acc_no_out2", out_valid_a, 1'b0);
        drive(8'h04, 8'h00, 2'b10, 1'b1, 1'b1); tick();
        chk("acc_data", out_data_a, 8'h07);
        chk("acc_count", out_count_a, 8'd3);
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
        chk("acc_parity", par_a, 1'b1);
`endif
        in_valid = 1'b0; tick();

        // Backpressure: result held, input stalled, then release+accept together.
        drive(8'hA5, 8'h0F, 2'b10, 1'b0, 1'b0); tick();
        chk("bp_first", out_data_a, 8'hAA);
`ifdef PARAM_LOGIC_ACCUM_PARITY_EN
        chk("bp_parity", par_a, 1'b0);
`endif
        out_ready = 1'b0;
        drive(8'hA5, 8'h0F, 2'b00, 1'b0, 1'b0);
        #1;
        chk("bp_stall_ready", in_ready_a, 1'b0);
        tick();
        chk("bp_hold", out_data_a, 8'hAA);
        tick();
        chk("bp_hold2", out_data_a, 8'hAA);
        out_ready = 1'b1;
        tick();
        chk("bp_next_valid", out_valid_a, 1'b1);
        chk("bp_next_data", out_data_a, 8'h05);
        in_valid = 1'b0; tick();

        // Mid-frame op/mode change is ignored; frame stays XOR.
        drive(8'h01, 8'h00, 2'b10, 1'b1, 1'b0); tick();
        drive(8'h03, 8'h01, 2'b00, 1'b0, 1'b0); tick();
        drive(8'hF0, 8'h0F, 2'b00, 1'b0, 1'b1); tick();
        chk("opq_data", out_data_a, 8'hFC);
        chk("opq_count", out_count_a, 8'd3);

        // Five-beat frame: CNT_W=2 instance saturates at 3.
        for (int i = 0; i < 5; i++) begin
            drive(8'(1 << i), 8'h00, 2'b10, 1'b1, i == 4);
            tick();
        end
        chk("sat5_data", out_data_a, 8'h1F);
        chk("sat5_count_a", out_count_a, 8'd5);
        chk("sat5_count_b", out_count_b, 2'd3);

        // Long frame saturates the 8-bit counter.
        for (int i = 0; i < 260; i++) begin
            drive(8'(i), 8'h5A, 2'b01, 1'b1, i == 259);
            tick();
        end
        chk("sat260_count", out_count_a, 8'd255);
        in_valid = 1'b0; tick();

        // Reset mid-frame discards the partial frame.
        drive(8'h01, 8'h00, 2'b10, 1'b1, 1'b0); tick();
        drive(8'h02, 8'h00, 2'b10, 1'b1, 1'b0); tick();
        do_reset();
        drive(8'h3C, 8'h00, 2'b01, 1'b1, 1'b1); tick();
        chk("post_rst_data", out_data_a, 8'h3C);
        chk("post_rst_count", out_count_a, 8'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            op        = 2'($urandom);
            mode      = 1'($urandom);
            in_last   = ($urandom % 3) == 0;
            out_ready = ($urandom % 10) < 7;
            tick();
        end

        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_logic_accum.md
Name: param_logic_accum

Overview:
- Parametrised, registered successor to the team's fixed-width combinational bitwise gate blocks.
- Applies a selectable bitwise operation (AND/OR/XOR/XNOR) to two WIDTH-bit operands, with valid/ready handshakes on input and output.
- Two modes:
  - Per-beat: one result per accepted beat.
  - Accumulate: XOR-folds every beat's result across a frame into a running checksum, emitted on the frame's last beat.
- Used as a datapath gate stage and as a frame checksum unit.

Parameters:
WIDTH, 4, operand/result width in bits (>=1)
CNT_W, 8, width of beat counter in accumulate mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_last  input  1  last beat of frame (accumulate mode only)
op  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR
mode  input  1  0 per-beat, 1 accumulate
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_count  output  CNT_W  beats in frame (accumulate); 1 in per-beat mode

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low. All state clears immediately on rst_n=0.
- Reset values: out_valid=0, out_data=0, out_count=0, acc=0, cnt=0, state=S_IDLE.
- Handshakes:
  - Accept = in_valid && in_ready; release = out_valid && out_ready.
  - in_ready = !out_valid || out_ready, combinational; it is a full-throughput single output register.
  - While out_valid=1 && out_ready=0, out_data and out_count hold stable.
- Beat result: r = in_a op in_b, full WIDTH, bitwise, no carries.
- State S_IDLE (no frame open):
  - On accept with mode=0: out_data<=r, out_count<=1, out_valid<=1 next cycle (latency 1); stay S_IDLE.
  - On accept with mode=1, in_last=1: single-beat frame. out_data<=r, out_count<=1, out_valid<=1; stay S_IDLE.
  - On accept with mode=1, in_last=0: acc<=r, cnt<=1, latch op_q<=op; go to S_ACC. out_valid is unaffected by this beat.
- State S_ACC (frame open):
  - op_q is used; op and mode inputs are ignored until the frame closes.
  - On accept with in_last=0: acc<=acc^r, cnt<=sat(cnt+1).
  - On accept with in_last=1: out_data<=acc^r, out_count<=sat(cnt+1), out_valid<=1; acc<=0, cnt<=0; go to S_IDLE.
  - sat() saturates at 2^CNT_W-1; it does not wrap.
- Simultaneous release and accept in the same cycle: the new result is loaded and out_valid stays 1. No bubble, no loss.
- Release with no result-producing accept: out_valid<=0.
- Non-last beats in S_ACC accept whenever in_ready=1. A non-last beat never overwrites a pending output.
- in_last is ignored when in S_IDLE with mode=0.
- Reset mid-frame: the partial frame is discarded; no output is produced for it.

Optional Feature:
- Macro: PARAM_LOGIC_ACCUM_PARITY_EN
- Defined:
  - Adds output port out_parity (1 bit) = reduction XOR of the value loaded into out_data.
  - Registered alongside out_data, same timing; reset value 0; held stable under backpressure.
- Undefined:
  - Port absent; no parity logic.
  - All other behaviour is identical.

Test Plan:
- Reset then per-beat mode, WIDTH=8, in_a=8'hA5, in_b=8'h0F, out_ready=1:
  - op=00 -> 8'h05; op=01 -> 8'hAF; op=10 -> 8'hAA; op=11 -> 8'h55.
  - Each result appears 1 cycle after accept, out_count=1.
- Accumulate mode, op=10, beats (01,00), (02,00), (04,00,last) -> single output out_data=8'h07, out_count=3; no output on the first two beats.
- Backpressure:
  - With out_ready=0 after the first result 8'hAA: in_ready=0, and out_data holds 8'hAA.
  - Raise out_ready while in_valid=1 with a new beat -> next result loads in the same cycle, out_valid stays 1.
- Mid-frame op change: frame started with op=10; op driven to 00 on beat 2 -> result still XOR-based (op_q).
  - Also CNT_W=2 with a 5-beat frame -> out_count=3 (saturated).
- Reset mid-frame: assert rst_n=0 after 2 beats -> out_valid=0 immediately.
  - After release, a 1-beat frame (8'h3C,8'h00,last) -> 8'h3C, out_count=1.
- With PARAM_LOGIC_ACCUM_PARITY_EN: result 8'hAA -> out_parity=0; result 8'h07 -> out_parity=1.
